// File: rtl/basic_uart_pkg.sv
// Shared types and constants for the basic UART transmitter and receiver.
package basic_uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    function automatic logic [15:0] calc_divisor(input int unsigned clk_fre, input int unsigned baud_rate);
        return 16'(clk_fre / baud_rate);
    endfunction

endpackage

// File: rtl/basic_uart_rx.sv
// UART receiver: synchronised line, mid-bit sampling, one checked stop bit.
module basic_uart_rx
    import basic_uart_pkg::*;
#(
    parameter logic [15:0] DIVISOR         = 16'd434,
    parameter logic        TRANS_BIT_ORDER = 1'b0
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx_dat_ser,
    output logic [7:0] rx_dat,
    output logic       rx_dat_ev
);

    localparam logic [15:0] HALF = DIVISOR >> 1;

    uart_state_t          state;
    logic [1:0]           sync;
    logic                 line;
    logic [15:0]          cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 frame_err;

    assign line = sync[1];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync      <= '1;
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            rx_dat    <= '0;
            rx_dat_ev <= 1'b0;
        end else begin
            sync      <= {sync[0], rx_dat_ser};
            rx_dat_ev <= 1'b0;
            cnt       <= cnt + 16'd1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!line) state <= START;
                end
                START: begin
                    if (cnt == HALF - 16'd1) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= line ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt == DIVISOR - 16'd1) begin
                        cnt     <= '0;
                        shift   <= TRANS_BIT_ORDER ? {shift[DATA_BITS-2:0], line}
                                                   : {line, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
                    end
                end
                STOP: begin
                    // After a framing error, hold here until the line returns high.
                    if (frame_err) begin
                        cnt <= '0;
                        if (line) begin
                            frame_err <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (cnt == DIVISOR - 16'd1) begin
                        cnt <= '0;
                        if (line) begin
                            rx_dat    <= shift;
                            rx_dat_ev <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/basic_uart_tx.sv
// UART transmitter: start bit, 8 data bits in the configured order, 1 or 2 stop bits.
module basic_uart_tx
    import basic_uart_pkg::*;
#(
    parameter logic [15:0] DIVISOR            = 16'd434,
    parameter logic        TRANS_BIT_ORDER    = 1'b0,
    parameter logic [1:0]  TRANS_STOP_BIT_NUM = 2'd1
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] tx_dat,
    input  logic       tx_wr_ev,
    output logic       tx_ready,
    output logic       tx_dat_ser,
    output logic       tx_done_ev
);

    localparam logic [2:0] LAST_STOP = (TRANS_STOP_BIT_NUM >= 2'd2) ? 3'd1 : 3'd0;

    uart_state_t          state;
    logic [15:0]          baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 bit_end;

    assign bit_end = (baud_cnt == DIVISOR - 16'd1);

    // tx_dat_ser is driven from the state of the previous cycle, so the
    // whole frame (and the done/ready edge) lags the state machine by one clock.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            tx_ready   <= 1'b1;
            tx_dat_ser <= 1'b1;
            tx_done_ev <= 1'b0;
        end else begin
            tx_done_ev <= 1'b0;
            baud_cnt   <= (state == IDLE || bit_end) ? '0 : baud_cnt + 16'd1;
            case (state)
                IDLE: begin
                    tx_dat_ser <= 1'b1;
                    if (!tx_ready) begin
                        tx_ready   <= 1'b1;
                        tx_done_ev <= 1'b1;
                    end else if (tx_wr_ev) begin
                        shift    <= tx_dat;
                        tx_ready <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    tx_dat_ser <= 1'b0;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    tx_dat_ser <= TRANS_BIT_ORDER ? shift[DATA_BITS-1] : shift[0];
                    if (bit_end) begin
                        shift <= TRANS_BIT_ORDER ? {shift[DATA_BITS-2:0], 1'b0}
                                                 : {1'b0, shift[DATA_BITS-1:1]};
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    tx_dat_ser <= 1'b1;
                    if (bit_end) begin
                        if (bit_cnt == LAST_STOP) state <= IDLE;
                        else                      bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/basic_uart_core.sv
// Full-duplex 8N1/8N2 UART: independent receiver and transmitter on one clock.
module basic_uart_core
    import basic_uart_pkg::*;
#(
    parameter int unsigned CLK_FRE            = 50_000_000,
    parameter int unsigned BAUD_RATE          = 115200,
    parameter logic [15:0] DIVISOR            = calc_divisor(CLK_FRE, BAUD_RATE),
    parameter logic        TRANS_BIT_ORDER    = 1'b0,
    parameter logic [1:0]  TRANS_STOP_BIT_NUM = 2'd1
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx_dat_ser,
    output logic [7:0] rx_dat,
    output logic       rx_dat_ev,
    input  logic [7:0] tx_dat,
    input  logic       tx_wr_ev,
    output logic       tx_ready,
    output logic       tx_dat_ser,
    output logic       tx_done_ev
);

    basic_uart_rx #(
        .DIVISOR         (DIVISOR),
        .TRANS_BIT_ORDER (TRANS_BIT_ORDER)
    ) u_rx (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .rx_dat_ser (rx_dat_ser),
        .rx_dat     (rx_dat),
        .rx_dat_ev  (rx_dat_ev)
    );

    basic_uart_tx #(
        .DIVISOR            (DIVISOR),
        .TRANS_BIT_ORDER    (TRANS_BIT_ORDER),
        .TRANS_STOP_BIT_NUM (TRANS_STOP_BIT_NUM)
    ) u_tx (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .tx_dat     (tx_dat),
        .tx_wr_ev   (tx_wr_ev),
        .tx_ready   (tx_ready),
        .tx_dat_ser (tx_dat_ser),
        .tx_done_ev (tx_done_ev)
    );

endmodule

// File: tb/tb_basic_uart_core.sv
// Bench for basic_uart_core: a default instance (LSB first, 1 stop) and a fast
// instance (MSB first, stop setting 3 -> 2 stop bits) looped TX->RX.
`timescale 1ns/1ps
module tb_basic_uart_core;

    localparam longint DIV0 = 434;
    localparam longint S0   = 1;
    localparam bit     ORD0 = 1'b0;
    localparam longint DIV1 = 10;
    localparam longint S1   = 2;
    localparam bit     ORD1 = 1'b1;
    localparam longint NONE = -1000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_dat0 = '0, tx_dat1 = '0;
    logic       wr0 = 1'b0, wr1 = 1'b0;
    logic       rx_pin0 = 1'b1, loop0 = 1'b0;
    logic       rx_ser0, rx_ser1;
    logic [7:0] rx_dat0, rx_dat1;
    logic       rx_ev0, rx_ev1, ready0, ready1, tx_ser0, tx_ser1, done0, done1;

    assign rx_ser0 = loop0 ? tx_ser0 : rx_pin0;
    assign rx_ser1 = tx_ser1;

    always #5 clk = ~clk;

    basic_uart_core #(
        .CLK_FRE   (50_000_000),
        .BAUD_RATE (115200)
    ) u_dut0 (
        .sys_clk (clk), .rst (rst), .rx_dat_ser (rx_ser0), .rx_dat (rx_dat0), .rx_dat_ev (rx_ev0),
        .tx_dat (tx_dat0), .tx_wr_ev (wr0), .tx_ready (ready0), .tx_dat_ser (tx_ser0), .tx_done_ev (done0)
    );

    basic_uart_core #(
        .DIVISOR            (16'd10),
        .TRANS_BIT_ORDER    (1'b1),
        .TRANS_STOP_BIT_NUM (2'd3)
    ) u_dut1 (
        .sys_clk (clk), .rst (rst), .rx_dat_ser (rx_ser1), .rx_dat (rx_dat1), .rx_dat_ev (rx_ev1),
        .tx_dat (tx_dat1), .tx_wr_ev (wr1), .tx_ready (ready1), .tx_dat_ser (tx_ser1), .tx_done_ev (done1)
    );

    typedef struct {
        logic [7:0] b;
        longint     lo;
        longint     hi;
    } rx_exp_t;

    int         vectors = 0, misses = 0;
    longint     cyc = 0;
    longint     e0 = NONE, e1 = NONE;
    logic [7:0] b0 = '0, b1 = '0, rxl0 = '0, rxl1 = '0;
    rx_exp_t    q0[$], q1[$];
    bit         d1_done = 1'b0;

    // ---------------- reference model (frame arithmetic) ----------------
    function automatic longint frame_end(input longint e, input longint div, input longint s);
        return e + 1 + (9 + s) * div;
    endfunction

    function automatic bit busy(input longint c, input longint e, input longint div, input longint s);
        return (c >= e) && (c < frame_end(e, div, s));
    endfunction

    function automatic logic ser_at(input longint c, input longint e, input logic [7:0] b,
                                    input longint div, input longint s, input bit ord);
        longint k, bi;
        k = c - (e + 1);
        if (k < 0 || k >= (10 + s) * div) return 1'b1;
        bi = k / div;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return ord ? b[8 - int'(bi)] : b[int'(bi) - 1];
        return 1'b1;
    endfunction

    // p = edge after which the start bit appears on the RX pin.
    function automatic rx_exp_t rx_window(input logic [7:0] b, input longint p, input longint div);
        rx_exp_t x;
        x.b  = b;
        x.lo = p + 2 + div / 2 + 9 * div;
        x.hi = x.lo + 1;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            misses++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        misses++;
        $display("FAIL %s @cycle %0d: expected event did not occur", name, cyc);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            e0 = NONE; e1 = NONE; rxl0 = '0; rxl1 = '0;
            q0.delete(); q1.delete();
        end else begin
            if (wr0 && !busy(cyc - 1, e0, DIV0, S0)) begin
                e0 = cyc; b0 = tx_dat0;
                if (loop0) q0.push_back(rx_window(tx_dat0, cyc + 1, DIV0));
            end
            if (wr1 && !busy(cyc - 1, e1, DIV1, S1)) begin
                e1 = cyc; b1 = tx_dat1;
                q1.push_back(rx_window(tx_dat1, cyc + 1, DIV1));
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        rx_exp_t x;
        if (cyc > 0) begin
            check("tx0_ser",   {31'd0, tx_ser0}, {31'd0, ser_at(cyc, e0, b0, DIV0, S0, ORD0)});
            check("tx0_ready", {31'd0, ready0},  {31'd0, !busy(cyc, e0, DIV0, S0)});
            check("tx0_done",  {31'd0, done0},   {31'd0, cyc == frame_end(e0, DIV0, S0)});
            check("tx1_ser",   {31'd0, tx_ser1}, {31'd0, ser_at(cyc, e1, b1, DIV1, S1, ORD1)});
            check("tx1_ready", {31'd0, ready1},  {31'd0, !busy(cyc, e1, DIV1, S1)});
            check("tx1_done",  {31'd0, done1},   {31'd0, cyc == frame_end(e1, DIV1, S1)});

            if (rx_ev0 === 1'b1) begin
                if (q0.size() == 0) check("rx0_unexpected_event", 32'd1, 32'd0);
                else begin
                    x = q0.pop_front();
                    check("rx0_event_time", {31'd0, cyc >= x.lo && cyc <= x.hi}, 32'd1);
                    check("rx0_byte", {24'd0, rx_dat0}, {24'd0, x.b});
                    rxl0 = x.b;
                end
            end else if (q0.size() > 0 && cyc > q0[0].hi) begin
                fail_now("rx0_event_missing");
                void'(q0.pop_front());
            end
            check("rx0_dat_hold", {24'd0, rx_dat0}, {24'd0, rxl0});

            if (rx_ev1 === 1'b1) begin
                if (q1.size() == 0) check("rx1_unexpected_event", 32'd1, 32'd0);
                else begin
                    x = q1.pop_front();
                    check("rx1_event_time", {31'd0, cyc >= x.lo && cyc <= x.hi}, 32'd1);
                    check("rx1_byte", {24'd0, rx_dat1}, {24'd0, x.b});
                    rxl1 = x.b;
                end
            end else if (q1.size() > 0 && cyc > q1[0].hi) begin
                fail_now("rx1_event_missing");
                void'(q1.pop_front());
            end
            check("rx1_dat_hold", {24'd0, rx_dat1}, {24'd0, rxl1});
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_cycle(input longint target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic wait_ready0();
        int n = 0;
        while (ready0 !== 1'b1 && n < 20000) begin @(posedge clk); #1; n++; end
        if (ready0 !== 1'b1) fail_now("tx0_ready_timeout");
    endtask

    task automatic wait_ready1();
        int n = 0;
        while (ready1 !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
        if (ready1 !== 1'b1) fail_now("tx1_ready_timeout");
    endtask

    task automatic write0(input logic [7:0] d);
        tx_dat0 = d; wr0 = 1'b1;
        @(posedge clk); #1;
        wr0 = 1'b0;
    endtask

    task automatic write1(input logic [7:0] d);
        tx_dat1 = d; wr1 = 1'b1;
        @(posedge clk); #1;
        wr1 = 1'b0;
    endtask

    task automatic rx_send0(input logic [7:0] d, input logic stop);
        if (stop) q0.push_back(rx_window(d, cyc, DIV0));
        rx_pin0 = 1'b0;
        repeat (DIV0) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_pin0 = d[i];
            repeat (DIV0) @(posedge clk);
            #1;
        end
        rx_pin0 = stop;
        repeat (DIV0) @(posedge clk);
        #1;
    endtask

    task automatic drain0();
        int n = 0;
        while (q0.size() != 0 && n < 3 * int'(DIV0)) begin @(posedge clk); #1; n++; end
        if (q0.size() != 0) fail_now("rx0_drain_timeout");
    endtask

    // Second instance: fixed MSB-first frame, then random looped traffic.
    initial begin
        bit     exp81 [11] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        longint e;
        int     n;
        while (rst) begin @(posedge clk); #1; end
        wait_ready1();
        write1(8'h81);
        e = e1;
        for (int i = 0; i < 11; i++) begin
            wait_cycle(e + 1 + longint'(i) * DIV1 + DIV1 / 2);
            check("tx1_81_bit", {31'd0, tx_ser1}, {31'd0, exp81[i]});
        end
        n = 0;
        while (done1 !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
        if (done1 !== 1'b1) fail_now("tx1_done_timeout");
        else check("tx1_frame_len", 32'(cyc - e), 32'd111);
        for (int k = 0; k < 40; k++) begin
            wait_ready1();
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            write1(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 60)) begin @(posedge clk); #1; end
                write1(8'($urandom));
            end
        end
        n = 0;
        while (q1.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
        if (q1.size() != 0) fail_now("rx1_drain_timeout");
        d1_done = 1'b1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit     expa5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [7:0] lb [5];
        longint e;
        int     n;

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_tx0_ser",   {31'd0, tx_ser0}, 32'd1);
        check("rst_tx0_ready", {31'd0, ready0},  32'd1);
        check("rst_rx0_dat",   {24'd0, rx_dat0}, 32'h00);
        check("rst_rx0_ev",    {31'd0, rx_ev0},  32'd0);
        check("rst_tx1_ser",   {31'd0, tx_ser1}, 32'd1);
        rst = 1'b0;

        // TX 8'hA5, LSB first, one stop bit; a second write mid-frame is dropped.
        wait_ready0();
        write0(8'hA5);
        e = e0;
        for (int i = 0; i < 10; i++) begin
            wait_cycle(e + 1 + longint'(i) * DIV0 + DIV0 / 2);
            check("tx0_a5_bit", {31'd0, tx_ser0}, {31'd0, expa5[i]});
            if (i == 3) write0(8'hFF);
        end
        n = 0;
        while (done0 !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
        if (done0 !== 1'b1) fail_now("tx0_done_timeout");
        else check("tx0_done_latency", 32'(cyc - e), 32'd4341);

        // RX back-to-back frames.
        rx_send0(8'h3C, 1'b1);
        rx_send0(8'hC3, 1'b1);
        drain0();
        check("rx0_last_c3", {24'd0, rx_dat0}, 32'hC3);

        // Short glitch, then a framing error, then a good frame to show re-arm.
        rx_pin0 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx_pin0 = 1'b1;
        repeat (2 * DIV0) @(posedge clk);
        #1;
        rx_send0(8'h96, 1'b0);
        rx_pin0 = 1'b1;
        repeat (2 * DIV0) @(posedge clk);
        #1;
        check("rx0_frame_err_hold", {24'd0, rx_dat0}, 32'hC3);
        rx_send0(8'($urandom), 1'b1);
        drain0();

        // Loopback.
        lb[0] = 8'($urandom); lb[1] = 8'($urandom);
        lb[2] = 8'h00; lb[3] = 8'hFF; lb[4] = 8'h5A;
        loop0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_ready0();
            write0(lb[i]);
        end
        wait_ready0();
        drain0();
        check("loop0_last_5a", {24'd0, rx_dat0}, 32'h5A);
        loop0 = 1'b0;

        // Reset in the middle of a TX frame.
        n = 0;
        while (!d1_done && n < 20000) begin @(posedge clk); #1; n++; end
        if (!d1_done) fail_now("dut1_traffic_timeout");
        wait_ready0();
        write0(8'h55);
        repeat (1000) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx0_ser",   {31'd0, tx_ser0}, 32'd1);
        check("abort_tx0_ready", {31'd0, ready0},  32'd1);
        check("abort_rx0_dat",   {24'd0, rx_dat0}, 32'h00);
        rst = 1'b0;
        repeat (5000) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
